free_list_ctrl: RTL and testbench
=================================

# free_list_ctrl

Physical-register free-list controller for the rename stage. It hands out free physical tags to the renamer one per cycle over a valid/ready handshake and takes back freed tags from retirement. On a pipeline flush it recovers speculative allocations by rewinding to the committed head. It sits between the rename table (consumer of `alloc_tag`) and the retire logic (producer of `commit_ena`/`release_*`).

## Interface
- `NUM_PREGS`, 16, number of physical registers; power of two.
- `NUM_AREGS`, 8, architectural registers; tags 0..NUM_AREGS-1 are mapped at reset and never enter the initial free list.
- `TAG_W`, $clog2(NUM_PREGS), physical tag width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `alloc_valid` in 1: renamer requests a tag this cycle.
- `alloc_ready` out 1: a tag is available and the block is in RUN.
- `alloc_tag` out TAG_W: tag granted when `alloc_valid && alloc_ready`; 0 when `!alloc_ready`.
- `commit_ena` in 1: oldest allocated tag is now architectural; advances the commit head.
- `release_ena` in 1: push `release_tag` onto the free list.
- `release_tag` in TAG_W: tag freed by retirement (the old mapping).
- `flush` in 1: discard all uncommitted allocations.
- `free_count` out TAG_W+1: speculative free entries (tail − spec_head).
- `busy` out 1: state ≠ RUN.
- `dup_err` out 1: sticky double-free flag (see Configuration).

## Operation
- Storage: circular buffer of NUM_PREGS tags. Pointers `tail`, `spec_head`, and `commit_head` are each TAG_W+1 bits and wrap modulo 2·NUM_PREGS. The index is the low TAG_W bits.
- Counts: spec = tail − spec_head; commit = tail − commit_head. Required invariant: spec ≤ commit ≤ NUM_PREGS.
- States:
  - INIT: entered from reset. `init_idx` starts at NUM_AREGS. Each cycle, write `init_idx` at `tail`, then increment `tail` and `init_idx`. After writing NUM_PREGS-1, go to RUN. Duration is NUM_PREGS−NUM_AREGS cycles.
  - RUN: normal operation.
  - RECOVER: lasts exactly one cycle after a flush, then returns to RUN.
- `alloc_ready` = (state==RUN) && spec≠0 && !flush.
- Grant: `alloc_tag` = buf[spec_head] (show-ahead). On fire, spec_head increments.
- `commit_ena`: commit_head increments. Issuing it when commit_head==spec_head is illegal.
- `release_ena`: buf[tail] = release_tag, then tail increments. Issuing it when commit==NUM_PREGS is illegal.
- Flush cycle (RUN only):
  - No grant.
  - Commit and release in the same cycle are still processed.
  - At the edge, spec_head ← commit_head' (commit_head' includes that cycle's commit increment). State → RECOVER.
- Flush during INIT or RECOVER is ignored.
- commit/release during INIT is ignored.
- Simultaneous alloc and release when spec==0: no bypass. The released tag becomes grantable the next cycle.
- Simultaneous alloc, commit, and release in RUN: all three take effect in the same cycle.
- Reset values: state INIT, all pointers 0, `alloc_ready` 0, `alloc_tag` 0, `free_count` 0, `busy` 1, `dup_err` 0. Async reset mid-operation forces these immediately.

## Timing
- Grant latency is 0: tag, ready and valid are all seen in the same cycle.
- `free_count` and pointers update at the clock edge following the event.
- The only combinational input→output path is `flush`→`alloc_ready`. `alloc_valid` must not feed `alloc_ready`.
- Recovery cost: flush cycle + 1 RECOVER cycle, then grants resume.

## Configuration
- `FREE_LIST_DUPCHK_EN` defined:
  - Maintain a NUM_PREGS-bit `is_free` bitmap. Set on INIT write and on release; clear on grant.
  - Rebuild the bitmap on flush from the buffer contents between commit_head' and tail.
  - A release of a tag already free is dropped (tail unchanged) and sets `dup_err`, which stays set until reset.
- Not defined: no bitmap, every release is pushed, and `dup_err` is tied 0.

## Structure
- `free_list_pkg` holds:
  - `fl_state_t` enum {INIT, RUN, RECOVER}.
  - Default NUM_PREGS/NUM_AREGS localparams.
  - The `preg_tag_t` typedef, shared with the renamer.
- One sub-module, `tag_ring`, contains the buffer array and the write port. Its read port is combinational at an arbitrary pointer. The controller owns all pointers and the FSM.

## Test plan
- Reset, then idle. `busy`=1 for 8 cycles. After that: `busy`=0, `free_count`=8, `alloc_ready`=1, `alloc_tag`=8.
- `alloc_valid` held for 9 cycles. Grants are tags 8..15 in order. In the 9th cycle, `alloc_ready`=0 and `free_count`=0.
- Free list empty, `release_tag`=3 with `alloc_valid`=1 in the same cycle. No grant that cycle. Next cycle: `alloc_ready`=1, `alloc_tag`=3.
- Grant 8, 9, 10. Then one `commit_ena`. Then `flush`. Required: `alloc_ready`=0 for the flush and RECOVER cycles, then `alloc_tag`=9 and `free_count`=7.
- With `FREE_LIST_DUPCHK_EN`, after init, release tag 12: `dup_err`=1 and `free_count` stays 8. Without the macro: `free_count`=9 and `dup_err`=0.
- Assert `rst` asynchronously mid-grant. All outputs take reset values before the next edge, and INIT restarts.

Source files
------------

// File: rtl/free_list_ctrl_pkg.sv
// free_list_pkg: shared types and default sizes for the rename-stage
// physical-register free list.
//   fl_state_t   : controller state (INIT fills the list, RUN serves,
//                  RECOVER is the single bubble after a flush)
//   preg_tag_t   : physical register tag, shared with the renamer
package free_list_pkg;

  localparam int FL_NUM_PREGS = 16;
  localparam int FL_NUM_AREGS = 8;
  localparam int FL_TAG_W     = $clog2(FL_NUM_PREGS);

  typedef logic [FL_TAG_W-1:0] preg_tag_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } fl_state_t;

endpackage

// File: rtl/free_list_ctrl_if.sv
// free_list_ctrl_if: handshake bundle between the free-list controller and
// its neighbours (renamer consumes alloc_*, retire logic drives commit/release).
//   master : renamer / retire side (drives requests, sees grants and status)
//   slave  : free_list_ctrl
interface free_list_ctrl_if
  import free_list_pkg::*;
#(
  parameter int NUM_PREGS = FL_NUM_PREGS
);
  localparam int TAG_W = $clog2(NUM_PREGS);

  logic             alloc_valid;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             commit_ena;
  logic             release_ena;
  logic [TAG_W-1:0] release_tag;
  logic             flush;
  logic [TAG_W:0]   free_count;
  logic             busy;
  logic             dup_err;

  modport master (
    output alloc_valid, commit_ena, release_ena, release_tag, flush,
    input  alloc_ready, alloc_tag, free_count, busy, dup_err
  );

  modport slave (
    input  alloc_valid, commit_ena, release_ena, release_tag, flush,
    output alloc_ready, alloc_tag, free_count, busy, dup_err
  );

endinterface

// File: rtl/free_list_ctrl_tag_ring.sv
// tag_ring: circular storage for free physical tags.
//   clk          : clock (storage has no reset; contents are only read
//                  inside the valid pointer window)
//   we/waddr/wdata : single write port
//   raddr/rdata  : combinational read port at any index
//   mem_o        : full contents, only with FREE_LIST_DUPCHK_EN (bitmap rebuild)
module tag_ring #(
  parameter int NUM_PREGS = 16,
  parameter int TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [TAG_W-1:0] waddr,
  input  logic [TAG_W-1:0] wdata,
  input  logic [TAG_W-1:0] raddr,
  output logic [TAG_W-1:0] rdata
`ifdef FREE_LIST_DUPCHK_EN
  ,
  output logic [NUM_PREGS-1:0][TAG_W-1:0] mem_o
`endif
);

  logic [NUM_PREGS-1:0][TAG_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

`ifdef FREE_LIST_DUPCHK_EN
  assign mem_o = mem_q;
`endif

endmodule

// File: rtl/free_list_ctrl.sv
// free_list_ctrl: physical-register free-list controller.
// Hands out one free tag per cycle (show-ahead, zero latency), takes back
// released tags from retirement, and on flush rewinds the speculative head
// to the committed head.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : free_list_ctrl_if.slave (alloc / commit / release / flush,
//              free_count, busy, dup_err)
// Optional feature: FREE_LIST_DUPCHK_EN adds an is_free bitmap that drops
// double-frees and raises the sticky dup_err flag.
module free_list_ctrl
  import free_list_pkg::*;
#(
  parameter int NUM_PREGS = FL_NUM_PREGS,
  parameter int NUM_AREGS = FL_NUM_AREGS
) (
  input  logic            clk,
  input  logic            rst,
  free_list_ctrl_if.slave bus
);

  localparam int TAG_W = $clog2(NUM_PREGS);
  localparam int PTR_W = TAG_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  fl_state_t        state_q, state_d;
  ptr_t             tail_q, tail_d;
  ptr_t             spec_head_q, spec_head_d;
  ptr_t             commit_head_q, commit_head_d;
  logic [TAG_W-1:0] init_idx_q, init_idx_d;
  logic             busy_q, busy_d;
  logic             dup_err_q, dup_err_d;

  logic             we;
  logic [TAG_W-1:0] wdata;
  logic [TAG_W-1:0] rd_tag;
  ptr_t             spec_cnt;
  logic             run, proc, fire, rel_dup, rel_acc;

`ifdef FREE_LIST_DUPCHK_EN
  logic [NUM_PREGS-1:0]            is_free_q, is_free_d;
  logic [NUM_PREGS-1:0][TAG_W-1:0] ring_mem;
  ptr_t                            keep_cnt, pos;
  logic [TAG_W-1:0]                ent;
`endif

  tag_ring #(.NUM_PREGS(NUM_PREGS), .TAG_W(TAG_W)) u_ring (
    .clk   (clk),
    .we    (we),
    .waddr (tail_q[TAG_W-1:0]),
    .wdata (wdata),
    .raddr (spec_head_q[TAG_W-1:0]),
    .rdata (rd_tag)
`ifdef FREE_LIST_DUPCHK_EN
    ,
    .mem_o (ring_mem)
`endif
  );

  assign run      = (state_q == RUN);
  assign proc     = (state_q != INIT);   // commit/release honoured in RUN and RECOVER
  assign spec_cnt = tail_q - spec_head_q;

  // flush is the only input allowed to reach alloc_ready combinationally
  assign bus.alloc_ready = run && (spec_cnt != '0) && !bus.flush;
  assign bus.alloc_tag   = bus.alloc_ready ? rd_tag : '0;
  assign bus.free_count  = spec_cnt;
  assign bus.busy        = busy_q;
  assign fire            = bus.alloc_valid && bus.alloc_ready;

`ifdef FREE_LIST_DUPCHK_EN
  assign rel_dup     = is_free_q[bus.release_tag];
  assign bus.dup_err = dup_err_q;
`else
  assign rel_dup     = 1'b0;
  assign bus.dup_err = 1'b0;
`endif
  assign rel_acc = proc && bus.release_ena && !rel_dup;

  always_comb begin
    state_d       = state_q;
    tail_d        = tail_q;
    spec_head_d   = spec_head_q;
    commit_head_d = commit_head_q;
    init_idx_d    = init_idx_q;
    dup_err_d     = dup_err_q;
    we            = 1'b0;
    wdata         = bus.release_tag;
    unique case (state_q)
      INIT: begin
        we         = 1'b1;
        wdata      = init_idx_q;
        tail_d     = tail_q + PTR_ONE;
        init_idx_d = init_idx_q + TAG_W'(1);
        if (init_idx_q == TAG_W'(NUM_PREGS - 1)) state_d = RUN;
      end
      default: begin
        if (bus.commit_ena) commit_head_d = commit_head_q + PTR_ONE;
        if (rel_acc) begin
          we     = 1'b1;
          tail_d = tail_q + PTR_ONE;
        end
        if (bus.release_ena && rel_dup) dup_err_d = 1'b1;
        if (fire) spec_head_d = spec_head_q + PTR_ONE;
        if (state_q == RECOVER) begin
          state_d = RUN;
        end else if (bus.flush) begin
          // rewind past everything not yet committed, including this cycle's commit
          spec_head_d = commit_head_d;
          state_d     = RECOVER;
        end
      end
    endcase
    busy_d = (state_d != RUN);
  end

`ifdef FREE_LIST_DUPCHK_EN
  always_comb begin
    is_free_d = is_free_q;
    keep_cnt  = tail_d - commit_head_d;
    pos       = '0;
    ent       = '0;
    if (state_q == INIT) is_free_d[init_idx_q] = 1'b1;
    if (fire)            is_free_d[rd_tag] = 1'b0;
    if (rel_acc)         is_free_d[bus.release_tag] = 1'b1;
    if (run && bus.flush) begin
      // after the rewind the free set is exactly the window commit_head'..tail'
      is_free_d = '0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        pos = commit_head_d + ptr_t'(i);
        // the slot written this cycle is not in the array yet
        ent = (rel_acc && (pos[TAG_W-1:0] == tail_q[TAG_W-1:0])) ?
              bus.release_tag : ring_mem[pos[TAG_W-1:0]];
        if (ptr_t'(i) < keep_cnt) is_free_d[ent] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INIT;
      tail_q        <= '0;
      spec_head_q   <= '0;
      commit_head_q <= '0;
      init_idx_q    <= TAG_W'(NUM_AREGS);
      busy_q        <= 1'b1;
      dup_err_q     <= 1'b0;
`ifdef FREE_LIST_DUPCHK_EN
      is_free_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tail_q        <= tail_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      init_idx_q    <= init_idx_d;
      busy_q        <= busy_d;
      dup_err_q     <= dup_err_d;
`ifdef FREE_LIST_DUPCHK_EN
      is_free_q     <= is_free_d;
`endif
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// tb_free_list_ctrl: directed + randomized bench for free_list_ctrl.
// Reference model: the committed window is a queue of tags (front = commit
// head, back = tail); nspec counts granted-but-uncommitted tags, so the
// next grant is q[nspec] and free_count is q.size()-nspec.
module tb_free_list_ctrl;
  import free_list_pkg::*;

`ifdef FREE_LIST_DUPCHK_EN
  localparam bit DUPCHK = 1'b1;
`else
  localparam bit DUPCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  free_list_ctrl_if bus ();
  free_list_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int npass = 0;
  int ntot  = 0;

  preg_tag_t q[$];
  int        nspec;
  int        m_init;
  bit        m_rec;
  bit        m_dup;
  preg_tag_t m_next;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int mfree();
    return q.size() - nspec;
  endfunction

  function automatic bit mrdy(bit fl);
    return (m_init == 0) && !m_rec && (mfree() != 0) && !fl;
  endfunction

  function automatic bit in_free(preg_tag_t t);
    for (int i = nspec; i < q.size(); i++) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // set inputs (caller is at a negedge), let them settle, compare to model
  task automatic drive(bit av, bit ce, bit re, preg_tag_t rt, bit fl);
    bus.alloc_valid = av;
    bus.commit_ena  = ce;
    bus.release_ena = re;
    bus.release_tag = rt;
    bus.flush       = fl;
    #1;
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(mrdy(fl)));
    chk("alloc_tag",   32'(bus.alloc_tag),   mrdy(fl) ? 32'(q[nspec]) : 32'd0);
    chk("free_count",  32'(bus.free_count),  32'(mfree()));
    chk("busy",        32'(bus.busy),        32'((m_init != 0) || m_rec));
    chk("dup_err",     32'(bus.dup_err),     32'(m_dup));
  endtask

  // advance model across the posedge, return at the next negedge
  task automatic tick();
    @(posedge clk);
    if (m_init > 0) begin
      q.push_back(m_next);
      m_next = m_next + 1'b1;
      m_init--;
    end else begin
      bit fl;
      bit rdy;
      bit dup;
      fl  = bus.flush;
      rdy = mrdy(fl);
      dup = DUPCHK && bus.release_ena && in_free(bus.release_tag);
      if (rdy && bus.alloc_valid) nspec++;
      if (bus.commit_ena) begin
        void'(q.pop_front());
        nspec--;
      end
      if (bus.release_ena) begin
        if (dup) m_dup = 1'b1;
        else     q.push_back(bus.release_tag);
      end
      if (m_rec)   m_rec = 1'b0;
      else if (fl) begin
        nspec = 0;
        m_rec = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    nspec  = 0;
    m_init = FL_NUM_PREGS - FL_NUM_AREGS;
    m_next = preg_tag_t'(FL_NUM_AREGS);
    m_rec  = 1'b0;
    m_dup  = 1'b0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ready"}, 32'(bus.alloc_ready), 32'd0);
    chk({tag, "_tag"},   32'(bus.alloc_tag),   32'd0);
    chk({tag, "_fc"},    32'(bus.free_count),  32'd0);
    chk({tag, "_busy"},  32'(bus.busy),        32'd1);
    chk({tag, "_dup"},   32'(bus.dup_err),     32'd0);
  endtask

  task automatic do_reset();
    bus.alloc_valid = 1'b0;
    bus.commit_ena  = 1'b0;
    bus.release_ena = 1'b0;
    bus.release_tag = '0;
    bus.flush       = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(int n);
    repeat (n) begin
      drive(0, 0, 0, '0, 0);
      tick();
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.alloc_valid = 1'b0;
    bus.commit_ena  = 1'b0;
    bus.release_ena = 1'b0;
    bus.release_tag = '0;
    bus.flush       = 1'b0;
    model_reset();
    @(negedge clk);

    // init sequence: 8 busy cycles, then tags 8..15 available
    do_reset();
    idle(8);
    drive(0, 0, 0, '0, 0);
    chk("post_init_busy",  32'(bus.busy),        32'd0);
    chk("post_init_fc",    32'(bus.free_count),  32'd8);
    chk("post_init_ready", 32'(bus.alloc_ready), 32'd1);
    chk("post_init_tag",   32'(bus.alloc_tag),   32'd8);

    // drain: grants 8..15, then empty
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, '0, 0);
      if (i < 8) chk("drain_tag", 32'(bus.alloc_tag), 32'(8 + i));
      else begin
        chk("drain_empty_ready", 32'(bus.alloc_ready), 32'd0);
        chk("drain_empty_fc",    32'(bus.free_count),  32'd0);
      end
      tick();
    end

    // release into empty list with alloc pending: no bypass
    drive(1, 0, 1, 4'd3, 0);
    chk("nobypass_ready", 32'(bus.alloc_ready), 32'd0);
    tick();
    drive(0, 0, 0, '0, 0);
    chk("nobypass_next_ready", 32'(bus.alloc_ready), 32'd1);
    chk("nobypass_next_tag",   32'(bus.alloc_tag),   32'd3);
    tick();

    // grant 8,9,10; commit one; flush; RECOVER; resume at 9
    do_reset();
    idle(8);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, '0, 0);
      chk("pre_flush_tag", 32'(bus.alloc_tag), 32'(8 + i));
      tick();
    end
    drive(0, 1, 0, '0, 0);
    tick();
    drive(1, 0, 0, '0, 1);
    chk("flush_ready", 32'(bus.alloc_ready), 32'd0);
    tick();
    drive(1, 0, 0, '0, 0);
    chk("recover_ready", 32'(bus.alloc_ready), 32'd0);
    chk("recover_busy",  32'(bus.busy),        32'd1);
    tick();
    drive(0, 0, 0, '0, 0);
    chk("resume_tag", 32'(bus.alloc_tag),  32'd9);
    chk("resume_fc",  32'(bus.free_count), 32'd7);
    tick();

    // double free of tag 12 right after init
    do_reset();
    idle(8);
    drive(0, 0, 1, 4'd12, 0);
    tick();
    drive(0, 0, 0, '0, 0);
`ifdef FREE_LIST_DUPCHK_EN
    chk("dup_flag", 32'(bus.dup_err),    32'd1);
    chk("dup_fc",   32'(bus.free_count), 32'd8);
`else
    chk("dup_flag", 32'(bus.dup_err),    32'd0);
    chk("dup_fc",   32'(bus.free_count), 32'd9);
`endif
    tick();

    // randomized legal traffic against the model
    do_reset();
    idle(8);
    for (int n = 0; n < 600; n++) begin
      bit        av, ce, re, fl;
      preg_tag_t rt;
      av = ($urandom_range(0, 3) != 0);
      ce = (nspec > 0) && ($urandom_range(0, 1) == 1);
      re = (q.size() < FL_NUM_PREGS) && ($urandom_range(0, 2) == 0);
      rt = preg_tag_t'($urandom_range(0, FL_NUM_PREGS - 1));
      fl = ($urandom_range(0, 19) == 0);
      drive(av, ce, re, rt, fl);
      tick();
    end

    // async reset in the middle of a grant
    do_reset();
    idle(8);
    drive(1, 0, 0, '0, 0);
    chk("mid_grant_ready", 32'(bus.alloc_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst             = 1'b0;
    bus.alloc_valid = 1'b0;
    model_reset();
    idle(8);
    drive(0, 0, 0, '0, 0);
    chk("reinit_tag", 32'(bus.alloc_tag), 32'd8);
    chk("reinit_fc",  32'(bus.free_count), 32'd8);
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
